// File: rtl/lcd_frame_streamer.sv
// Frame pixel source for the LCD GPU port: reads a full frame linearly from a
// fixed-latency memory and streams it out through a small FIFO with a registered head.
module lcd_frame_streamer #(
   parameter int H_RES      = 320,
   parameter int V_RES      = 240,
   parameter int ADDR_W     = 17,
   parameter int FIFO_DEPTH = 8,
   parameter int RD_LAT     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              frame_trig,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       gpu_data,
   output logic              gpu_valid,
   input  logic              gpu_ready,
   output logic              busy,
   output logic              frame_done
);

   localparam int PIX   = H_RES * V_RES;
   localparam int CNT_W = (PIX > 1) ? $clog2(PIX) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX - 1);
   localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [1:0]        rst_sync;
   logic              rst_i_n;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  rd_cnt;
   logic [RD_LAT-1:0] rd_pipe;
   logic [OCC_W-1:0]  occ;
   logic [15:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [OCC_W-1:0]  fifo_cnt;
   logic              push, pop, head_free, fifo_empty, fifo_wr, fifo_rd, bypass;
   logic              start, drained, done_nxt;

   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_i_n = rst_sync[1];

   always_comb begin
      push       = rd_pipe[RD_LAT-1];
      pop        = gpu_valid & gpu_ready;
      head_free  = !gpu_valid | pop;
      fifo_empty = (fifo_cnt == '0);
      fifo_rd    = head_free & !fifo_empty;
      bypass     = push & head_free & fifo_empty;
      fifo_wr    = push & !bypass;
      drained    = (rd_pipe == '0) & fifo_empty & head_free;
   end

   // occ covers in-flight reads, stored words and the head, so a read is only
   // issued when a slot is guaranteed to exist when its data returns.
   always_comb begin
      state_nxt = state;
      mem_rd    = 1'b0;
      done_nxt  = 1'b0;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (frame_trig && ena) begin
               state_nxt = RUN;
               start     = 1'b1;
            end
         end
         RUN: begin
            if (occ < DEPTH_C) begin
               mem_rd = 1'b1;
               if (rd_cnt == LAST_PIX) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (drained) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_addr = mem_rd ? (base_q + ADDR_W'(rd_cnt)) : '0;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         state      <= IDLE;
         base_q     <= '0;
         rd_cnt     <= '0;
         rd_pipe    <= '0;
         occ        <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= done_nxt;
         rd_pipe    <= RD_LAT'({rd_pipe, mem_rd});
         occ        <= occ + OCC_W'(mem_rd) - OCC_W'(pop);
         if (start) begin
            base_q <= base_addr;
            rd_cnt <= '0;
         end else if (mem_rd) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) fifo_mem[wr_ptr] <= mem_rdata;
   end

   // The head register is the first-word-fall-through output; an empty FIFO
   // lets returning data go straight to it to save a cycle of latency.
   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         gpu_data  <= '0;
         gpu_valid <= 1'b0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt + OCC_W'(fifo_wr) - OCC_W'(fifo_rd);
         if (fifo_rd) begin
            gpu_data  <= fifo_mem[rd_ptr];
            gpu_valid <= 1'b1;
         end else if (bypass) begin
            gpu_data  <= mem_rdata;
            gpu_valid <= 1'b1;
         end else if (pop) begin
            gpu_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Scenario bench for lcd_frame_streamer on a 4x2 frame with a 2-cycle memory
// returning addr[15:0]^A5A5; expected addresses/pixels are queued at trigger time.
module tb_lcd_frame_streamer;

   localparam int H_RES = 4, V_RES = 2, ADDR_W = 17, FIFO_DEPTH = 4, RD_LAT = 2;
   localparam int NPIX = H_RES * V_RES;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ena = 1'b0;
   logic              frame_trig = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [15:0]       mem_rdata = 16'h0;
   logic [15:0]       gpu_data;
   logic              gpu_valid;
   logic              gpu_ready = 1'b0;
   logic              busy;
   logic              frame_done;

   lcd_frame_streamer #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W),
                        .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .frame_trig(frame_trig),
      .base_addr(base_addr), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_rdata(mem_rdata), .gpu_data(gpu_data), .gpu_valid(gpu_valid),
      .gpu_ready(gpu_ready), .busy(busy), .frame_done(frame_done));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: data appears exactly two cycles after the read strobe, junk otherwise.
   logic [ADDR_W-1:0] mem_a1 = '0;
   logic              mem_v1 = 1'b0;
   always @(posedge clk) begin
      mem_a1    <= mem_addr;
      mem_v1    <= mem_rd;
      mem_rdata <= mem_v1 ? (mem_a1[15:0] ^ 16'hA5A5) : 16'hDEAD;
   end

   logic [ADDR_W-1:0] rd_addr_log[$];
   int                rd_cyc_log[$];
   logic [15:0]       px_log[$];
   int                px_cyc_log[$];
   int                done_cyc_log[$];
   int                stab_viol = 0;
   logic              prev_valid = 1'b0, prev_ready = 1'b0;
   logic [15:0]       prev_data = 16'h0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_rd) begin
            rd_addr_log.push_back(mem_addr);
            rd_cyc_log.push_back(cyc);
         end
         if (gpu_valid && gpu_ready) begin
            px_log.push_back(gpu_data);
            px_cyc_log.push_back(cyc);
         end
         if (frame_done) done_cyc_log.push_back(cyc);
         if (prev_valid && !prev_ready && (!gpu_valid || gpu_data !== prev_data))
            stab_viol <= stab_viol + 1;
      end
      prev_valid <= gpu_valid;
      prev_ready <= gpu_ready;
      prev_data  <= gpu_data;
   end

   logic [15:0]       exp_px[$];
   logic [ADDR_W-1:0] exp_addr[$];
   int checks = 0;
   int errors = 0;

   task automatic start_frame(input logic [ADDR_W-1:0] base, input logic en,
                              input logic accept, output int t);
      logic [ADDR_W-1:0] a;
      @(posedge clk); #1;
      frame_trig = 1'b1; ena = en; base_addr = base; t = cyc;
      if (accept) begin
         for (int i = 0; i < NPIX; i++) begin
            a = base + ADDR_W'(i);
            exp_addr.push_back(a);
            exp_px.push_back(a[15:0] ^ 16'hA5A5);
         end
      end
      @(posedge clk); #1;
      frame_trig = 1'b0;
   endtask

   task automatic wait_frame(input int d0, input int budget, output logic ok);
      ok = 1'b0;
      for (int k = 0; k < budget && !ok; k++) begin
         @(posedge clk); #1;
         if (done_cyc_log.size() > d0) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      #2;
      checks++; if (gpu_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b required=0", gpu_valid); end
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd got=%b required=0", mem_rd); end
      checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_done got=%b%b required=00", busy, frame_done); end
      checks++; if (mem_addr !== '0 || gpu_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_addr_data got=%h/%h required=0/0", mem_addr, gpu_data); end
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      checks++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle got=%b%b required=00", busy, mem_rd); end
   endtask

   task automatic test_basic;
      int t, p0, a0, d0; logic ok; logic [15:0] e; logic [ADDR_W-1:0] ea;
      gpu_ready = 1'b1;
      p0 = px_log.size(); a0 = rd_addr_log.size(); d0 = done_cyc_log.size();
      start_frame(17'h00100, 1'b1, 1'b1, t);
      wait_frame(d0, 100, ok);
      repeat (3) @(posedge clk);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_done_timeout got=0 required=1"); end
      checks++; if (rd_addr_log.size() - a0 !== NPIX) begin errors++; $display("[TB] FAIL basic_rd_count got=%0d required=%0d", rd_addr_log.size() - a0, NPIX); end
      for (int i = 0; i < NPIX; i++) begin
         ea = exp_addr.pop_front(); e = exp_px.pop_front();
         checks++; if (rd_addr_log[a0+i] !== ea || rd_cyc_log[a0+i] !== t + 1 + i) begin errors++; $display("[TB] FAIL basic_rd%0d got=%h@%0d required=%h@%0d", i, rd_addr_log[a0+i], rd_cyc_log[a0+i], ea, t + 1 + i); end
         checks++; if (px_log[p0+i] !== e || px_cyc_log[p0+i] !== t + 4 + i) begin errors++; $display("[TB] FAIL basic_px%0d got=%h@%0d required=%h@%0d", i, px_log[p0+i], px_cyc_log[p0+i], e, t + 4 + i); end
      end
      checks++; if (done_cyc_log.size() - d0 !== 1 || done_cyc_log[d0] !== t + 12) begin errors++; $display("[TB] FAIL basic_done got=%0d@%0d required=1@%0d", done_cyc_log.size() - d0, done_cyc_log[d0], t + 12); end
   endtask

   task automatic test_backpressure;
      int t, p0, a0, d0, s0; logic ok; logic [15:0] e;
      gpu_ready = 1'b0;
      p0 = px_log.size(); a0 = rd_addr_log.size(); d0 = done_cyc_log.size(); s0 = stab_viol;
      start_frame(17'h00100, 1'b1, 1'b1, t);
      repeat (20) @(posedge clk);
      #2;
      checks++; if (rd_addr_log.size() - a0 !== FIFO_DEPTH) begin errors++; $display("[TB] FAIL bp_rd_count got=%0d required=%0d", rd_addr_log.size() - a0, FIFO_DEPTH); end
      checks++; if (gpu_valid !== 1'b1 || gpu_data !== exp_px[0]) begin errors++; $display("[TB] FAIL bp_head got=%b/%h required=1/%h", gpu_valid, gpu_data, exp_px[0]); end
      @(posedge clk); #1; gpu_ready = 1'b1;
      wait_frame(d0, 100, ok);
      repeat (3) @(posedge clk);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_done_timeout got=0 required=1"); end
      checks++; if (stab_viol !== s0) begin errors++; $display("[TB] FAIL bp_stable got=%0d required=%0d", stab_viol, s0); end
      for (int i = 0; i < NPIX; i++) begin
         e = exp_px.pop_front(); void'(exp_addr.pop_front());
         checks++; if (px_log[p0+i] !== e) begin errors++; $display("[TB] FAIL bp_px%0d got=%h required=%h", i, px_log[p0+i], e); end
      end
      checks++; if (px_log.size() - p0 !== NPIX) begin errors++; $display("[TB] FAIL bp_px_count got=%0d required=%0d", px_log.size() - p0, NPIX); end
   endtask

   task automatic test_lcd_pacing;
      int t, p0, d0; logic ok, v, r; logic [15:0] e;
      gpu_ready = 1'b0; ok = 1'b0;
      p0 = px_log.size(); d0 = done_cyc_log.size();
      start_frame(17'h00A00, 1'b1, 1'b1, t);
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clk); v = gpu_valid; r = gpu_ready;
         @(posedge clk); #1; gpu_ready = v && !r;
         if (done_cyc_log.size() > d0) ok = 1'b1;
      end
      gpu_ready = 1'b0;
      checks++; if (!ok) begin errors++; $display("[TB] FAIL lcd_done_timeout got=0 required=1"); end
      for (int i = 0; i < NPIX; i++) begin
         e = exp_px.pop_front(); void'(exp_addr.pop_front());
         checks++; if (px_log[p0+i] !== e || px_cyc_log[p0+i] !== t + 5 + 2 * i) begin errors++; $display("[TB] FAIL lcd_px%0d got=%h@%0d required=%h@%0d", i, px_log[p0+i], px_cyc_log[p0+i], e, t + 5 + 2 * i); end
      end
      checks++; if (done_cyc_log[d0] !== t + 20) begin errors++; $display("[TB] FAIL lcd_done_cycle got=%0d required=%0d", done_cyc_log[d0], t + 20); end
   endtask

   task automatic test_retrigger;
      int t, t2, p0, a0, d0; logic ok, saw_busy; logic [15:0] e; logic [ADDR_W-1:0] ea;
      gpu_ready = 1'b1;
      p0 = px_log.size(); a0 = rd_addr_log.size(); d0 = done_cyc_log.size();
      start_frame(17'h00200, 1'b1, 1'b1, t);
      start_frame(17'h00300, 1'b1, 1'b0, t2);
      wait_frame(d0, 100, ok);
      repeat (10) @(posedge clk);
      checks++; if (!ok || done_cyc_log.size() - d0 !== 1) begin errors++; $display("[TB] FAIL retrig_done_count got=%0d required=1", done_cyc_log.size() - d0); end
      checks++; if (rd_addr_log.size() - a0 !== NPIX) begin errors++; $display("[TB] FAIL retrig_rd_count got=%0d required=%0d", rd_addr_log.size() - a0, NPIX); end
      for (int i = 0; i < NPIX; i++) begin
         ea = exp_addr.pop_front(); e = exp_px.pop_front();
         checks++; if (rd_addr_log[a0+i] !== ea || px_log[p0+i] !== e) begin errors++; $display("[TB] FAIL retrig_%0d got=%h/%h required=%h/%h", i, rd_addr_log[a0+i], px_log[p0+i], ea, e); end
      end
      a0 = rd_addr_log.size(); saw_busy = 1'b0;
      start_frame(17'h00400, 1'b0, 1'b0, t);
      for (int k = 0; k < 15; k++) begin @(negedge clk); if (busy) saw_busy = 1'b1; end
      checks++; if (saw_busy !== 1'b0 || rd_addr_log.size() !== a0) begin errors++; $display("[TB] FAIL ena0_ignored got=busy%b/rd%0d required=busy0/rd0", saw_busy, rd_addr_log.size() - a0); end
   endtask

   task automatic test_addr_wrap;
      int t, p0, a0, d0; logic ok; logic [15:0] e; logic [ADDR_W-1:0] ea;
      gpu_ready = 1'b1;
      p0 = px_log.size(); a0 = rd_addr_log.size(); d0 = done_cyc_log.size();
      start_frame(17'h1FFFE, 1'b1, 1'b1, t);
      wait_frame(d0, 100, ok);
      repeat (3) @(posedge clk);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_done_timeout got=0 required=1"); end
      checks++; if (rd_addr_log[a0+2] !== 17'h00000) begin errors++; $display("[TB] FAIL wrap_third_addr got=%h required=00000", rd_addr_log[a0+2]); end
      for (int i = 0; i < NPIX; i++) begin
         ea = exp_addr.pop_front(); e = exp_px.pop_front();
         checks++; if (rd_addr_log[a0+i] !== ea || px_log[p0+i] !== e) begin errors++; $display("[TB] FAIL wrap_%0d got=%h/%h required=%h/%h", i, rd_addr_log[a0+i], px_log[p0+i], ea, e); end
      end
   endtask

   task automatic test_reset_mid_frame;
      int t, p0, a0, d0, k; logic ok; logic [15:0] e; logic [ADDR_W-1:0] ea;
      gpu_ready = 1'b1;
      p0 = px_log.size(); d0 = done_cyc_log.size();
      start_frame(17'h00500, 1'b1, 1'b1, t);
      k = 0;
      while (px_log.size() < p0 + 3 && k < 50) begin @(negedge clk); k++; end
      checks++; if (px_log.size() < p0 + 3) begin errors++; $display("[TB] FAIL abort_3px_timeout got=%0d required=3", px_log.size() - p0); end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++; if (gpu_valid !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_async got=v%b/rd%b/busy%b required=000", gpu_valid, mem_rd, busy); end
      exp_px.delete(); exp_addr.delete();
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      repeat (5) @(posedge clk);
      checks++; if (done_cyc_log.size() !== d0) begin errors++; $display("[TB] FAIL abort_no_done got=%0d required=0", done_cyc_log.size() - d0); end
      p0 = px_log.size(); a0 = rd_addr_log.size();
      start_frame(17'h00600, 1'b1, 1'b1, t);
      wait_frame(d0, 100, ok);
      repeat (3) @(posedge clk);
      checks++; if (!ok || done_cyc_log.size() - d0 !== 1) begin errors++; $display("[TB] FAIL restart_done got=%0d required=1", done_cyc_log.size() - d0); end
      checks++; if (px_log.size() - p0 !== NPIX) begin errors++; $display("[TB] FAIL restart_px_count got=%0d required=%0d", px_log.size() - p0, NPIX); end
      for (int i = 0; i < NPIX; i++) begin
         ea = exp_addr.pop_front(); e = exp_px.pop_front();
         checks++; if (rd_addr_log[a0+i] !== ea || px_log[p0+i] !== e) begin errors++; $display("[TB] FAIL restart_%0d got=%h/%h required=%h/%h", i, rd_addr_log[a0+i], px_log[p0+i], ea, e); end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      test_reset();
      test_basic();
      test_backpressure();
      test_lcd_pacing();
      test_retrigger();
      test_addr_wrap();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
